// File: rtl/seq_div73.sv
// Sequential restoring divider: P = Q*Y + R, one quotient bit per clock.
// Start/busy/done handshake; a zero divisor finishes at once with DZ set.
module seq_div73 #(
   parameter int unsigned PW = 7,
   parameter int unsigned YW = 3
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic [PW-1:0] P,
   input  logic [YW-1:0] Y,
   output logic          BUSY,
   output logic          DONE,
   output logic [PW-1:0] Q,
   output logic [YW-1:0] R,
   output logic          DZ
);

   localparam int unsigned CW = (PW > 1) ? $clog2(PW) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [PW-1:0] sh_q;
   logic [YW-1:0] dvs_q;
   logic [YW-1:0] rem_q;
   logic          busy_q;
   logic          done_q;
   logic [PW-1:0] q_q;
   logic [YW-1:0] r_q;
   logic          dz_q;

   logic [YW:0]   rem_sh;
   logic          qbit;
   logic [YW-1:0] rem_d;
   logic [PW-1:0] sh_d;

   // The dividend shifts out of sh_q's MSB while quotient bits shift in at
   // the LSB. After a restoring step the remainder is below the divisor, so
   // only the shifted compare value needs the extra bit.
   always_comb begin
      rem_sh = {rem_q, sh_q[PW-1]};
      qbit   = (rem_sh >= {1'b0, dvs_q});
      rem_d  = qbit ? YW'(rem_sh - {1'b0, dvs_q}) : rem_sh[YW-1:0];
      sh_d   = {sh_q[PW-2:0], qbit};
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
         dz_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (START) begin
                  if (Y != '0) begin
                     sh_q    <= P;
                     dvs_q   <= Y;
                     rem_q   <= '0;
                     cnt_q   <= CW'(PW - 1);
                     busy_q  <= 1'b1;
                     state_q <= CALC;
                  end else begin
                     q_q     <= '1;
                     r_q     <= '0;
                     dz_q    <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= FIN;
                  end
               end
            end
            CALC: begin
               rem_q <= rem_d;
               sh_q  <= sh_d;
               if (cnt_q == '0) begin
                  q_q     <= sh_d;
                  r_q     <= rem_d;
                  dz_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= FIN;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            FIN: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign Q    = q_q;
   assign R    = r_q;
   assign DZ   = dz_q;

endmodule
